fetch_ctrl: RTL and testbench

Sequences instruction fetch for the IF stage. Owns the fetch PC and drives a request/grant/response handshake to the instruction memory, with one request outstanding. Delivers instr/PC/PC+4 to the IF/ID boundary with a valid/ready handshake. Handles stalls through a one-entry skid buffer, and handles pipeline redirects (branch/jump) by flushing and discarding stale responses.

---
 rtl/fetch_ctrl_if.sv | 30 +++
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_fetch_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fetch_ctrl_if : imem request/grant/response and IF/ID handshake   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [31:0]     out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_instr,
    output imem_gnt, imem_rvalid, imem_rdata, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fetch_ctrl : IF-stage fetch sequencer, one outstanding request,   |
// |              one-entry skid buffer, redirect flush/drain          |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  fetch_ctrl_if.master    fb
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [31:0]     out_instr;

  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] req_pc_plus4;
  logic            slot_free;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign req_pc_plus4 = req_pc + XLEN'(4);
  assign slot_free    = !out_valid || fb.out_ready;

  assign fb.imem_req     = (state == S_FETCH) && !reset;
  assign fb.imem_addr    = pc;
  assign fb.out_valid    = out_valid;
  assign fb.out_pc       = out_pc;
  assign fb.out_pc_plus4 = out_pc_plus4;
  assign fb.out_instr    = out_instr;
  assign busy            = (state == S_WAIT) || (state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      req_pc       <= '0;
      skid_pc      <= '0;
      skid_instr   <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_pc_plus4 <= '0;
      out_instr    <= '0;
    end else if (redirect_i) begin
      pc         <= redirect_tgt;
      out_valid  <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      // Drain only if a response is still owed after this edge
      case (state)
        S_FETCH: state <= fb.imem_gnt ? S_DRAIN : S_FETCH;
        S_WAIT:  state <= fb.imem_rvalid ? S_FETCH : S_DRAIN;
        S_DRAIN: state <= fb.imem_rvalid ? S_FETCH : S_DRAIN;
        default: state <= S_FETCH;
      endcase
    end else begin
      if (out_valid && fb.out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_FETCH: begin
          if (fb.imem_gnt) begin
            req_pc <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fb.imem_rvalid) begin
            pc <= req_pc_plus4;
            if (slot_free) begin
              out_valid    <= 1'b1;
              out_pc       <= req_pc;
              out_pc_plus4 <= req_pc_plus4;
              out_instr    <= fb.imem_rdata;
              state        <= S_FETCH;
            end else begin
              skid_pc    <= req_pc;
              skid_instr <= fb.imem_rdata;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (fb.out_ready) begin
            out_valid    <= 1'b1;
            out_pc       <= skid_pc;
            out_pc_plus4 <= skid_pc + XLEN'(4);
            out_instr    <= skid_instr;
            state        <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (fb.imem_rvalid) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_fetch_ctrl : directed cycle-by-cycle vectors for fetch_ctrl    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic        busy;

  fetch_ctrl_if #(.XLEN(32)) bus ();

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .redirect_i  (redirect_i),
    .redirect_pc (redirect_pc),
    .busy        (busy),
    .fb          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   miscompares = 0;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'h1300_0000 ^ a;
  endfunction

  function automatic vec_t mk(
    input logic rst, input logic redir, input logic [31:0] rpc,
    input logic gnt, input logic rv, input logic [31:0] rdata, input logic rdy,
    input logic e_req, input logic [31:0] e_addr, input logic e_busy,
    input logic e_ov, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_busy = e_busy; v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = ins(e_pc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, nvec, act, exp);
    end
  endtask

  // Drive on the falling edge, check just after; the rising edge in between commits.
  task automatic apply(input vec_t v);
    @(negedge clk);
    reset           = v.rst;
    redirect_i      = v.redir;
    redirect_pc     = v.rpc;
    bus.imem_gnt    = v.gnt;
    bus.imem_rvalid = v.rv;
    bus.imem_rdata  = v.rdata;
    bus.out_ready   = v.rdy;
    #1;
    chk("imem_req", 32'(bus.imem_req), 32'(v.e_req));
    chk("imem_addr", bus.imem_addr, v.e_addr);
    chk("busy", 32'(busy), 32'(v.e_busy));
    chk("out_valid", 32'(bus.out_valid), 32'(v.e_ov));
    if (v.e_ov) begin
      chk("out_pc", bus.out_pc, v.e_pc);
      chk("out_pc_plus4", bus.out_pc_plus4, v.e_pc + 32'd4);
      chk("out_instr", bus.out_instr, v.e_instr);
    end
    nvec++;
  endtask

  initial begin
    reset = 1'b1; redirect_i = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // rst redir rpc gnt rv rdata rdy | req addr busy ov pc
    // Reset state and zero-wait streaming
    tbl.push_back(mk(1,0,0,0,0,0,1, 0,32'h0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'h0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,ins(32'h0),1, 0,32'h0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'h4,0,1,32'h0));
    tbl.push_back(mk(0,0,0,0,1,ins(32'h4),1, 0,32'h4,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'h8,0,1,32'h4));
    tbl.push_back(mk(0,0,0,0,1,ins(32'h8),1, 0,32'h8,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,32'hC,0,1,32'h8));
    // Stall: second response into skid, no further request, then release
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'hC,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,ins(32'hC),0, 0,32'hC,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 1,32'h10,0,1,32'hC));
    tbl.push_back(mk(0,0,0,0,1,ins(32'h10),0, 0,32'h10,1,1,32'hC));
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,32'h14,0,1,32'hC));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,32'h14,0,1,32'hC));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,32'h14,0,1,32'hC));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,32'h14,0,1,32'hC));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,32'h14,0,1,32'h10));
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'h14,0,0,0));
    // Redirect in WAIT with delayed response
    tbl.push_back(mk(0,1,32'h100,0,0,0,1, 0,32'h14,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,32'h100,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,32'h100,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,ins(32'h14),1, 0,32'h100,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'h100,0,0,0));
    // Redirect to unaligned target coincident with rvalid
    tbl.push_back(mk(0,1,32'h203,0,1,ins(32'h100),1, 0,32'h100,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,32'h200,0,0,0));
    // Back-to-back redirects while draining
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'h200,0,0,0));
    tbl.push_back(mk(0,1,32'h40,0,0,0,1, 0,32'h200,1,0,0));
    tbl.push_back(mk(0,1,32'h80,0,0,0,1, 0,32'h40,1,0,0));
    tbl.push_back(mk(0,0,0,0,1,ins(32'h200),1, 0,32'h80,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'h80,0,0,0));
    // Reset in HOLD with both slots full, stale rvalid afterwards
    tbl.push_back(mk(0,0,0,0,1,ins(32'h80),0, 0,32'h80,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 1,32'h84,0,1,32'h80));
    tbl.push_back(mk(0,0,0,0,1,ins(32'h84),0, 0,32'h84,1,1,32'h80));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,32'h88,0,1,32'h80));
    tbl.push_back(mk(0,0,0,0,1,ins(32'h84),0, 1,32'h0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,32'h0,0,0,0));
    // PC+4 wrap at the top of the address space
    tbl.push_back(mk(0,1,32'hFFFF_FFFF,0,0,0,1, 1,32'h0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,1, 1,32'hFFFF_FFFC,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,ins(32'hFFFF_FFFC),1, 0,32'hFFFF_FFFC,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,32'h0,0,1,32'hFFFF_FFFC));
    // Redirect in FETCH together with grant must drain
    tbl.push_back(mk(0,1,32'h300,1,0,0,1, 1,32'h0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,ins(32'h0),1, 0,32'h300,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 1,32'h300,0,0,0));

    foreach (tbl[i]) apply(tbl[i]);

    // Redirect while holding a full skid: both slots flushed, no stall left
    apply(mk(0,0,0,1,0,0,0, 1,32'h300,0,0,0));
    apply(mk(0,0,0,0,1,ins(32'h300),0, 0,32'h300,1,0,0));
    apply(mk(0,0,0,1,0,0,0, 1,32'h304,0,1,32'h300));
    apply(mk(0,0,0,0,1,ins(32'h304),0, 0,32'h304,1,1,32'h300));
    apply(mk(0,1,32'h500,0,0,0,0, 0,32'h308,0,1,32'h300));
    apply(mk(0,0,0,0,0,0,1, 1,32'h500,0,0,0));
    apply(mk(0,0,0,1,0,0,1, 1,32'h500,0,0,0));
    apply(mk(0,0,0,0,1,ins(32'h500),1, 0,32'h500,1,0,0));
    apply(mk(0,0,0,0,0,0,1, 1,32'h504,0,1,32'h500));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
